// File: rtl/alut_arb_pkg.sv
// Shared types and constants for the ALUT memory arbiter: FSM encodings,
// requester indices and default memory geometry.
package alut_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_AC = 2'd1,
    LOCK_AG = 2'd2
  } arb_state_e;

  localparam int REQ_AC = 0;
  localparam int REQ_AG = 1;
  localparam int REQ_SW = 2;

  localparam int ALUT_AW = 8;
  localparam int ALUT_DW = 83;

endpackage

// File: rtl/alut_mem_arbiter_if.sv
// Requester-side bus of the ALUT arbiter: request/lock in, grant/read-data out.
// master = requester side, slave = arbiter side.
interface alut_mem_arbiter_if #(
  parameter int AW = alut_arb_pkg::ALUT_AW,
  parameter int DW = alut_arb_pkg::ALUT_DW
);
  logic          ac_req,   ag_req,   sw_req;
  logic          ac_we,    ag_we,    sw_we;
  logic [AW-1:0] ac_addr,  ag_addr,  sw_addr;
  logic [DW-1:0] ac_wdata, ag_wdata, sw_wdata;
  logic          ac_lock,  ag_lock;
  logic          ac_gnt,   ag_gnt,   sw_gnt;
  logic          ac_rvalid, ag_rvalid, sw_rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output ac_req, ag_req, sw_req, ac_we, ag_we, sw_we,
           ac_addr, ag_addr, sw_addr, ac_wdata, ag_wdata, sw_wdata,
           ac_lock, ag_lock,
    input  ac_gnt, ag_gnt, sw_gnt, ac_rvalid, ag_rvalid, sw_rvalid, rdata
  );

  modport slave (
    input  ac_req, ag_req, sw_req, ac_we, ag_we, sw_we,
           ac_addr, ag_addr, sw_addr, ac_wdata, ag_wdata, sw_wdata,
           ac_lock, ag_lock,
    output ac_gnt, ag_gnt, sw_gnt, ac_rvalid, ag_rvalid, sw_rvalid, rdata
  );
endinterface

// File: rtl/alut_arb_rd_pipe.sv
// Two-stage {valid, owner} shift tracking reads from grant to data return;
// rvalid and rdata appear two cycles after the grant, no backpressure.
module alut_arb_rd_pipe
  import alut_arb_pkg::*;
#(
  parameter int DW = ALUT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_vld,
  input  logic [1:0]    rd_owner,
  input  logic [DW-1:0] mem_rdata,
  output logic          ac_rvalid,
  output logic          ag_rvalid,
  output logic          sw_rvalid,
  output logic [DW-1:0] rdata,
  output logic          pipe_busy
);

  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;
  logic [1:0]    s1_own_q, s1_own_d;
  logic [1:0]    s2_own_q, s2_own_d;
  logic [DW-1:0] rdata_q,  rdata_d;

  always_comb begin
    s1_vld_d = rd_vld;
    s1_own_d = rd_owner;
    s2_vld_d = s1_vld_q;
    s2_own_d = s1_own_q;
    rdata_d  = s2_vld_q ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_own_q <= 2'd0;
      s2_vld_q <= 1'b0;
      s2_own_q <= 2'd0;
      rdata_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_own_q <= s1_own_d;
      s2_vld_q <= s2_vld_d;
      s2_own_q <= s2_own_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM data is only valid in the return cycle, so pass it straight through
  // then and hold the last value afterwards.
  assign rdata     = s2_vld_q ? mem_rdata : rdata_q;
  assign ac_rvalid = s2_vld_q && (s2_own_q == 2'(REQ_AC));
  assign ag_rvalid = s2_vld_q && (s2_own_q == 2'(REQ_AG));
  assign sw_rvalid = s2_vld_q && (s2_own_q == 2'(REQ_SW));
  assign pipe_busy = s1_vld_q || s2_vld_q;

endmodule

// File: rtl/alut_mem_arbiter.sv
// Arbiter/sequencer for the single-port ALUT RAM: combinational grant, command at T+1,
// read data at T+2; locked RMW and bounded sw wait. ALUT_ARB_STATS_EN adds conflict_cnt.
module alut_mem_arbiter
  import alut_arb_pkg::*;
#(
  parameter int SW_MAX_WAIT = 8,
  parameter int LOCK_MAX    = 4,
  parameter int AW          = ALUT_AW,
  parameter int DW          = ALUT_DW
) (
  input  logic                pclk,
  input  logic                p_reset,
  alut_mem_arbiter_if.slave   bus,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_we,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                arb_busy
`ifdef ALUT_ARB_STATS_EN
  ,
  output logic [15:0]         conflict_cnt
`endif
);

  localparam int SW_CW = $clog2(SW_MAX_WAIT + 1);
  localparam int LK_CW = $clog2(LOCK_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [SW_CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [LK_CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic       gnt_ac, gnt_ag, gnt_sw;
  logic       starved, locked_gnt;
  logic       rd_vld;
  logic [1:0] rd_owner;
  logic       pipe_busy;

  assign starved = (starve_cnt_q == SW_CW'(SW_MAX_WAIT));

  // Grants are held off during reset so nothing is granted that will be lost.
  always_comb begin
    gnt_ac = 1'b0;
    gnt_ag = 1'b0;
    gnt_sw = 1'b0;
    if (!p_reset) begin
      unique case (state_q)
        LOCK_AC: gnt_ac = bus.ac_req;
        LOCK_AG: gnt_ag = bus.ag_req;
        default: begin
          if (bus.sw_req && starved) gnt_sw = 1'b1;
          else if (bus.ac_req)       gnt_ac = 1'b1;
          else if (bus.ag_req)       gnt_ag = 1'b1;
          else if (bus.sw_req)       gnt_sw = 1'b1;
        end
      endcase
    end
  end

  assign locked_gnt = (gnt_ac && bus.ac_lock) || (gnt_ag && bus.ag_lock);

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    rd_vld       = 1'b0;
    rd_owner     = 2'(REQ_AC);

    unique case (state_q)
      IDLE: begin
        lock_cnt_d = '0;
        if (locked_gnt) begin
          state_d    = gnt_ac ? LOCK_AC : LOCK_AG;
          lock_cnt_d = LK_CW'(1);
        end
      end
      LOCK_AC, LOCK_AG: begin
        // Only the owner can be granted here, so locked_gnt is the owner's.
        if (locked_gnt && (lock_cnt_q < LK_CW'(LOCK_MAX - 1))) begin
          lock_cnt_d = lock_cnt_q + LK_CW'(1);
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase

    if (!bus.sw_req || gnt_sw) starve_cnt_d = '0;
    else if (!starved)         starve_cnt_d = starve_cnt_q + SW_CW'(1);

    if (gnt_ac) begin
      mem_addr_d  = bus.ac_addr;
      mem_we_d    = bus.ac_we;
      mem_wdata_d = bus.ac_wdata;
      rd_vld      = !bus.ac_we;
      rd_owner    = 2'(REQ_AC);
    end else if (gnt_ag) begin
      mem_addr_d  = bus.ag_addr;
      mem_we_d    = bus.ag_we;
      mem_wdata_d = bus.ag_wdata;
      rd_vld      = !bus.ag_we;
      rd_owner    = 2'(REQ_AG);
    end else if (gnt_sw) begin
      mem_addr_d  = bus.sw_addr;
      mem_we_d    = bus.sw_we;
      mem_wdata_d = bus.sw_wdata;
      rd_vld      = !bus.sw_we;
      rd_owner    = 2'(REQ_SW);
    end
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
      starve_cnt_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  alut_arb_rd_pipe #(.DW(DW)) u_rd_pipe (
    .clk       (pclk),
    .rst       (p_reset),
    .rd_vld    (rd_vld),
    .rd_owner  (rd_owner),
    .mem_rdata (mem_rdata),
    .ac_rvalid (bus.ac_rvalid),
    .ag_rvalid (bus.ag_rvalid),
    .sw_rvalid (bus.sw_rvalid),
    .rdata     (bus.rdata),
    .pipe_busy (pipe_busy)
  );

  assign bus.ac_gnt = gnt_ac;
  assign bus.ag_gnt = gnt_ag;
  assign bus.sw_gnt = gnt_sw;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign arb_busy   = gnt_ac || gnt_ag || gnt_sw || pipe_busy || (state_q != IDLE);

`ifdef ALUT_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        multi_req, lock_block;

  assign multi_req  = (2'(bus.ac_req) + 2'(bus.ag_req) + 2'(bus.sw_req)) >= 2'd2;
  assign lock_block = ((state_q == LOCK_AC) && (bus.ag_req || bus.sw_req)) ||
                      ((state_q == LOCK_AG) && (bus.ac_req || bus.sw_req));

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((multi_req || lock_block) && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge pclk) begin
    if (p_reset) conflict_cnt_q <= '0;
    else         conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alut_mem_arbiter.sv
// Directed bench for alut_mem_arbiter with a small synchronous RAM model;
// unwritten RAM words read back as 83'h50000 + address.
module tb_alut_mem_arbiter;
  import alut_arb_pkg::*;

  logic          pclk;
  logic          p_reset;
  logic [7:0]    mem_addr;
  logic          mem_we;
  logic [82:0]   mem_wdata;
  logic [82:0]   mem_rdata;
  logic          arb_busy;
`ifdef ALUT_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alut_mem_arbiter_if bus ();

  alut_mem_arbiter dut (
    .pclk      (pclk),
    .p_reset   (p_reset),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .arb_busy  (arb_busy)
`ifdef ALUT_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic [82:0] ram     [256];
  bit          wr_seen [256];

  always @(posedge pclk) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      wr_seen[mem_addr] <= 1'b1;
    end
    mem_rdata <= wr_seen[mem_addr] ? ram[mem_addr] : (83'h50000 + 83'(mem_addr));
  end

  logic [2:0] gnt_v, rv_v;
  assign gnt_v = {bus.ac_gnt, bus.ag_gnt, bus.sw_gnt};
  assign rv_v  = {bus.ac_rvalid, bus.ag_rvalid, bus.sw_rvalid};

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ac_req = 0; bus.ag_req = 0; bus.sw_req = 0;
    bus.ac_we  = 0; bus.ag_we  = 0; bus.sw_we  = 0;
    bus.ac_addr = '0; bus.ag_addr = '0; bus.sw_addr = '0;
    bus.ac_wdata = '0; bus.ag_wdata = '0; bus.sw_wdata = '0;
    bus.ac_lock = 0; bus.ag_lock = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    p_reset = 1;
    repeat (3) step();
    p_reset = 0;
    @(negedge pclk);
    n_tests++; if (gnt_v !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt_v); end
    n_tests++; if (rv_v !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 000", rv_v); end
    n_tests++; if (bus.rdata !== 83'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_tests++; if ({mem_addr, mem_we} !== 9'h0) begin n_fail++; $display("FAIL reset_mem_cmd: got %h/%b expected 0/0", mem_addr, mem_we); end
    n_tests++; if (mem_wdata !== 83'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    n_tests++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", arb_busy); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
    step();
  endtask

  task automatic test_single_read();
    bus.ac_req = 1; bus.ac_we = 0; bus.ac_addr = 8'h3C;
    @(negedge pclk);
    n_tests++; if (gnt_v !== 3'b100) begin n_fail++; $display("FAIL single_gnt: got %b expected 100", gnt_v); end
    step(); bus.ac_req = 0;
    @(negedge pclk);
    n_tests++; if ({mem_addr, mem_we} !== {8'h3C, 1'b0}) begin n_fail++; $display("FAIL single_cmd: got %h/%b expected 3c/0", mem_addr, mem_we); end
    n_tests++; if ({rv_v, arb_busy} !== 4'b0001) begin n_fail++; $display("FAIL single_t1: got rv %b busy %b expected 000/1", rv_v, arb_busy); end
    step();
    @(negedge pclk);
    n_tests++; if (rv_v !== 3'b100) begin n_fail++; $display("FAIL single_rvalid: got %b expected 100", rv_v); end
    n_tests++; if (bus.rdata !== 83'h5003C) begin n_fail++; $display("FAIL single_rdata: got %h expected 5003c", bus.rdata); end
    step();
    @(negedge pclk);
    n_tests++; if ({rv_v, arb_busy} !== 4'b0000) begin n_fail++; $display("FAIL single_t3: got rv %b busy %b expected 000/0", rv_v, arb_busy); end
    step();
  endtask

  task automatic test_all_three();
    logic [2:0]  eg [5];
    logic [2:0]  er [5];
    logic [82:0] ed [5];
    eg = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
    er = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001};
    ed = '{83'h0, 83'h0, 83'h50001, 83'h50002, 83'h50003};
    bus.ac_req = 1; bus.ac_addr = 8'h01;
    bus.ag_req = 1; bus.ag_addr = 8'h02;
    bus.sw_req = 1; bus.sw_addr = 8'h03;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) bus.ac_req = 0;
      if (c == 2) bus.ag_req = 0;
      if (c == 3) bus.sw_req = 0;
      @(negedge pclk);
      n_tests++; if (gnt_v !== eg[c]) begin n_fail++; $display("FAIL three_gnt c%0d: got %b expected %b", c, gnt_v, eg[c]); end
      n_tests++; if (rv_v !== er[c]) begin n_fail++; $display("FAIL three_rvalid c%0d: got %b expected %b", c, rv_v, er[c]); end
      if (c >= 2) begin
        n_tests++; if (bus.rdata !== ed[c]) begin n_fail++; $display("FAIL three_rdata c%0d: got %h expected %h", c, bus.rdata, ed[c]); end
      end
      step();
    end
  endtask

  task automatic test_rmw();
    bus.ac_req = 1; bus.ac_we = 0; bus.ac_lock = 1; bus.ac_addr = 8'h10;
    bus.ag_req = 1; bus.ag_we = 0; bus.ag_addr = 8'h10;
    @(negedge pclk);
    n_tests++; if (gnt_v !== 3'b100) begin n_fail++; $display("FAIL rmw_gnt0: got %b expected 100", gnt_v); end
    step();
    bus.ac_we = 1; bus.ac_lock = 0; bus.ac_wdata = 83'h1234;
    @(negedge pclk);
    n_tests++; if (gnt_v !== 3'b100) begin n_fail++; $display("FAIL rmw_gnt1: got %b expected 100", gnt_v); end
    n_tests++; if (dut.state_q !== LOCK_AC) begin n_fail++; $display("FAIL rmw_state: got %0d expected 1", dut.state_q); end
    step();
    bus.ac_req = 0; bus.ac_we = 0;
    @(negedge pclk);
    n_tests++; if (gnt_v !== 3'b010) begin n_fail++; $display("FAIL rmw_ag_gnt: got %b expected 010", gnt_v); end
    n_tests++; if ({rv_v, bus.rdata} !== {3'b100, 83'h50010}) begin n_fail++; $display("FAIL rmw_old_read: got %b/%h expected 100/50010", rv_v, bus.rdata); end
    n_tests++; if ({mem_addr, mem_we} !== {8'h10, 1'b1}) begin n_fail++; $display("FAIL rmw_write_cmd: got %h/%b expected 10/1", mem_addr, mem_we); end
    step();
    bus.ag_req = 0;
    @(negedge pclk);
    n_tests++; if ({gnt_v, rv_v} !== 6'b000000) begin n_fail++; $display("FAIL rmw_t3: got gnt %b rv %b expected 000/000", gnt_v, rv_v); end
    step();
    @(negedge pclk);
    n_tests++; if ({rv_v, bus.rdata} !== {3'b010, 83'h1234}) begin n_fail++; $display("FAIL rmw_new_read: got %b/%h expected 010/1234", rv_v, bus.rdata); end
    step();
  endtask

  task automatic test_starvation();
    bus.ac_req = 1; bus.ac_we = 0; bus.ac_addr = 8'h20;
    bus.sw_req = 1; bus.sw_we = 0; bus.sw_addr = 8'h30;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) bus.sw_req = 0;
      @(negedge pclk);
      if (k == 8) begin
        n_tests++; if (gnt_v !== 3'b001) begin n_fail++; $display("FAIL starve_sw_gnt k%0d: got %b expected 001", k, gnt_v); end
        n_tests++; if (dut.starve_cnt_q !== 4'd8) begin n_fail++; $display("FAIL starve_cnt_sat: got %0d expected 8", dut.starve_cnt_q); end
      end else begin
        n_tests++; if (gnt_v !== 3'b100) begin n_fail++; $display("FAIL starve_ac_gnt k%0d: got %b expected 100", k, gnt_v); end
      end
      if (k == 9) begin
        n_tests++; if (dut.starve_cnt_q !== 4'd0) begin n_fail++; $display("FAIL starve_cnt_clr: got %0d expected 0", dut.starve_cnt_q); end
      end
      step();
    end
    bus.ac_req = 0;
    repeat (3) step();
  endtask

  task automatic test_forced_release();
    logic [2:0] eg [6];
    eg = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000};
    bus.ag_req = 1; bus.ag_we = 0; bus.ag_lock = 1; bus.ag_addr = 8'h40;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin bus.ac_req = 1; bus.ac_we = 0; bus.ac_addr = 8'h41; end
      if (c == 5) begin bus.ac_req = 0; bus.ag_req = 0; bus.ag_lock = 0; end
      @(negedge pclk);
      n_tests++; if (gnt_v !== eg[c]) begin n_fail++; $display("FAIL lock_gnt c%0d: got %b expected %b", c, gnt_v, eg[c]); end
      if (c == 1) begin
        n_tests++; if (dut.state_q !== LOCK_AG) begin n_fail++; $display("FAIL lock_state_held: got %0d expected 2", dut.state_q); end
      end
      if (c == 4) begin
        n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL lock_state_released: got %0d expected 0", dut.state_q); end
      end
      step();
    end
    repeat (3) step();
  endtask

  task automatic test_reset_midop();
    bus.sw_req = 1; bus.sw_we = 0; bus.sw_addr = 8'h55;
    @(negedge pclk);
    n_tests++; if (gnt_v !== 3'b001) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 001", gnt_v); end
    step();
    bus.sw_req = 0; p_reset = 1;
    @(negedge pclk);
    n_tests++; if (mem_addr !== 8'h55) begin n_fail++; $display("FAIL midrst_cmd: got %h expected 55", mem_addr); end
    step();
    p_reset = 0;
    @(negedge pclk);
    n_tests++; if ({gnt_v, rv_v} !== 6'b000000) begin n_fail++; $display("FAIL midrst_rvalid: got gnt %b rv %b expected 000/000", gnt_v, rv_v); end
    n_tests++; if (bus.rdata !== 83'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", bus.rdata); end
    n_tests++; if ({mem_addr, mem_we, arb_busy} !== 10'h0) begin n_fail++; $display("FAIL midrst_cmd_busy: got %h/%b/%b expected 0/0/0", mem_addr, mem_we, arb_busy); end
    n_tests++; if (mem_wdata !== 83'h0) begin n_fail++; $display("FAIL midrst_wdata: got %h expected 0", mem_wdata); end
`ifdef ALUT_ARB_STATS_EN
    n_tests++; if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_conflict: got %0d expected 0", conflict_cnt); end
`endif
    step();
    @(negedge pclk);
    n_tests++; if (rv_v !== 3'b000) begin n_fail++; $display("FAIL midrst_late_rvalid: got %b expected 000", rv_v); end
    step();
  endtask

  initial begin
    p_reset = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_all_three();
    test_rmw();
    test_starvation();
    test_forced_release();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alut_mem_arbiter.md
Name: alut_mem_arbiter

Overview:
Arbiter and sequencer for the single-port 256 x 83 ALUT memory. The memory is shared by three requesters: the address checker (ac), the age checker (ag) and the APB software access path (sw).
- Grants one access per cycle and registers the memory command.
- Returns read data with a fixed latency.
- Supports locked read-modify-write sequences.
- Guarantees bounded software wait time.
Sits between the requesters and the ALUT RAM macro.

Parameters:
SW_MAX_WAIT, 8, cycles sw may be denied before it is promoted above ac/ag
LOCK_MAX, 4, maximum consecutive locked grants before forced release
AW, 8, memory address width
DW, 83, memory data width

Ports:
pclk  in  1  APB clock; single clock domain
p_reset  in  1  reset, synchronous, active-high
ac_req, ag_req, sw_req  in  1 each  access request; held until grant
ac_we, ag_we, sw_we  in  1 each  1=write, 0=read
ac_addr, ag_addr, sw_addr  in  AW each  memory address
ac_wdata, ag_wdata, sw_wdata  in  DW each  write data
ac_lock, ag_lock  in  1 each  keep ownership for the next cycle (RMW)
ac_gnt, ag_gnt, sw_gnt  out  1 each  combinational grant, one-hot or zero
ac_rvalid, ag_rvalid, sw_rvalid  out  1 each  read data valid for that requester
rdata  out  DW  read data shared by all requesters
mem_addr  out  AW  registered RAM address
mem_we  out  1  registered RAM write strobe
mem_wdata  out  DW  registered RAM write data
mem_rdata  in  DW  RAM read data, valid 1 cycle after mem_addr
arb_busy  out  1  grant issued, read in flight, or lock held

Behaviour:
- Reset values: all gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_we=0, mem_wdata=0, arb_busy=0, FSM=IDLE, starvation and lock counters=0.
- Reset asserted mid-operation clears everything, including reads in flight; no rvalid is issued for them.
- Grants are a combinational function of req and registered state; at most one gnt per cycle.
- A request whose req is low gets no grant. A requester must hold req, we, addr and wdata stable until gnt.
- Timing, relative to grant cycle T:
  - T+1: mem_addr, mem_we and mem_wdata present the granted access.
  - T+2: for a read, rdata=mem_rdata and the owner's rvalid=1 for exactly one cycle.
  - Writes produce no rvalid.
  - Throughput: one access per cycle. Back-to-back accesses reach the RAM in grant order, so a read granted after a write to the same address returns the new data.
- Priority, highest first: lock owner > starved sw > ac > ag > sw.
- Starvation counter:
  - Increments each cycle sw_req=1 and sw_gnt=0, saturating at SW_MAX_WAIT.
  - At SW_MAX_WAIT, sw wins the next cycle unless a lock is held.
  - Clears on sw_gnt or when sw_req=0.
- FSM states: IDLE, LOCK_AC, LOCK_AG.
  - IDLE -> LOCK_AC when ac is granted with ac_lock=1. IDLE -> LOCK_AG likewise for ag.
  - LOCK_xx: only xx may be granted. Stays in LOCK_xx while xx is granted with lock=1 and the lock counter is below LOCK_MAX-1.
  - LOCK_xx -> IDLE when xx is granted with lock=0, when xx_req=0 (no grant that cycle), or when the lock counter reaches LOCK_MAX-1 (forced release after that grant).
  - Lock counter increments on every locked grant and clears in IDLE.
- Lock interaction with starvation:
  - lock is ignored for sw.
  - A forced release always lets a starved sw win the next cycle.
- arb_busy = any gnt | any read in the T+1/T+2 pipeline | FSM != IDLE.

Optional Feature:
ALUT_ARB_STATS_EN:
- Defined: adds output conflict_cnt [15:0]. Reset 0. Increments by 1 each cycle two or more req are high, or a req is blocked by a lock. Saturates at 16'hFFFF and clears on p_reset only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alut_arb_pkg holds:
  - FSM state encodings IDLE=2'd0, LOCK_AC=2'd1, LOCK_AG=2'd2;
  - requester index constants REQ_AC=0, REQ_AG=1, REQ_SW=2;
  - the default widths AW/DW.
- One sub-module, alut_arb_rd_pipe: two-stage shift of {valid, owner} that generates the per-requester rvalid and captures rdata.

Test Plan:
- Reset then idle: ac_read addr 8'h3C at T -> ac_gnt at T, mem_addr=8'h3C with mem_we=0 at T+1, ac_rvalid=1 and rdata=mem_rdata at T+2; no other rvalid.
- ac, ag, sw all request in the same cycle -> grants in order ac, ag, sw on three consecutive cycles; three rvalids each 2 cycles after the matching grant.
- ac RMW: read with ac_lock=1 addr 8'h10, then write 8'h10 with lock=0, ag requesting throughout -> ag_gnt=0 for both ac cycles, ag granted the cycle after; a subsequent ag read of 8'h10 returns the written data.
- ac requests continuously while sw_req is high -> sw_gnt at exactly the 9th sw cycle (SW_MAX_WAIT=8), counter back to 0, then ac resumes.
- ag holds ag_lock=1 with continuous requests -> forced release after 4 grants, FSM=IDLE, a waiting ac is granted next cycle.
- p_reset pulsed one cycle after a sw read grant -> no sw_rvalid, all outputs at reset values; with ALUT_ARB_STATS_EN, conflict_cnt=0.
